// File: rtl/game_screen_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_screen_ctrl_pkg
// Description : Shared definitions for the game screen controller.
//               Holds the screen_sel encoding (also consumed by the RGB mux),
//               the controller state type and a binary-to-BCD helper.
// Revision    : 1.0 - initial release
// ============================================================================
package game_screen_ctrl_pkg;

  localparam logic [1:0] SCR_TITLE = 2'd0;
  localparam logic [1:0] SCR_PLAY  = 2'd1;
  localparam logic [1:0] SCR_WIN   = 2'd2;
  localparam logic [1:0] SCR_LOSE  = 2'd3;

  // State encoding equals the screen_sel encoding, so the state register
  // can drive screen_sel directly.
  typedef enum logic [1:0] {
    ST_TITLE = SCR_TITLE,
    ST_PLAY  = SCR_PLAY,
    ST_WIN   = SCR_WIN,
    ST_LOSE  = SCR_LOSE
  } state_e;

  // Two-digit BCD of a value in 0..99 as {tens, ones}.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_screen_ctrl_bcd_counter2.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter2
// Description : Two-digit BCD counter with load, increment and decrement.
//               Increment saturates at 99, decrement saturates at 00.
//               Load has priority over inc, inc over dec.
// Ports       : clk, reset (sync, active-low), load_i/load_val_i, inc_i,
//               dec_i, tens_o/ones_o (registered digits), zero_o (value==00)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter2 #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       zero_o
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       w_max;

  assign w_max  = (tens_q == 4'd9) && (ones_q == 4'd9);
  assign zero_o = (tens_q == 4'd0) && (ones_q == 4'd0);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load_i) begin
      tens_d = load_val_i[7:4];
      ones_d = load_val_i[3:0];
    end else if (inc_i && !w_max) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec_i && !zero_o) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tens_q <= RESET_VAL[7:4];
      ones_q <= RESET_VAL[3:0];
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule
`default_nettype wire

// File: rtl/game_screen_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_screen_ctrl
// Description : Round controller for a whack-a-mole game. Sequences
//               TITLE -> PLAY -> WIN/LOSE -> TITLE, keeps a BCD hit score
//               and a BCD seconds-remaining timer paced by vsync frames.
// Ports       : clk, reset (sync, active-low), vsync (active-low pulse),
//               start_btn, hit_pulse (single-cycle pulses);
//               screen_sel, score_tens/ones, time_tens/ones, game_active
//               (all registered).
// Revision    : 1.0 - initial release
// ============================================================================
module game_screen_ctrl
  import game_screen_ctrl_pkg::*;
#(
  parameter int unsigned ROUND_SECONDS  = 30,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned WIN_SCORE      = 20,
  parameter int unsigned RESULT_FRAMES  = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start_btn,
  input  logic       hit_pulse,
  output logic [1:0] screen_sel,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       game_active
);

  localparam int unsigned FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int unsigned RC_W = (RESULT_FRAMES > 1) ? $clog2(RESULT_FRAMES) : 1;
  localparam logic [7:0] ROUND_BCD = to_bcd(ROUND_SECONDS);
  localparam logic [7:0] WIN_BCD   = to_bcd(WIN_SCORE);

  state_e            state_q;
  logic              game_active_q;
  logic              vsync_q;
  logic [FC_W-1:0]   frame_cnt_q;
  logic [RC_W-1:0]   result_cnt_q;

  logic w_frame_tick;
  logic w_score_win;
  logic w_time_zero;
  logic w_play;
  logic w_live;
  logic w_sec_wrap;
  logic w_start_round;

  // vsync idles high; a high-to-low transition marks a new frame.
  assign w_frame_tick  = vsync_q && !vsync;
  assign w_score_win   = ({score_tens, score_ones} == WIN_BCD);
  assign w_play        = (state_q == ST_PLAY);
  // Once the win score or time 00 is registered the round is decided and
  // nothing may change until the state moves on.
  assign w_live        = w_play && !w_score_win && !w_time_zero;
  assign w_sec_wrap    = (frame_cnt_q == FC_W'(FRAMES_PER_SEC - 1));
  assign w_start_round = (state_q == ST_TITLE) && start_btn;

  bcd_counter2 #(.RESET_VAL(8'h00)) u_score (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_start_round),
    .load_val_i (8'h00),
    .inc_i      (w_live && hit_pulse),
    .dec_i      (1'b0),
    .tens_o     (score_tens),
    .ones_o     (score_ones),
    .zero_o     ()
  );

  bcd_counter2 #(.RESET_VAL(ROUND_BCD)) u_time (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_start_round),
    .load_val_i (ROUND_BCD),
    .inc_i      (1'b0),
    .dec_i      (w_live && w_frame_tick && w_sec_wrap),
    .tens_o     (time_tens),
    .ones_o     (time_ones),
    .zero_o     (w_time_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_TITLE;
      game_active_q <= 1'b0;
      vsync_q       <= 1'b1;
      frame_cnt_q   <= '0;
      result_cnt_q  <= '0;
    end else begin
      vsync_q <= vsync;
      case (state_q)
        ST_TITLE: begin
          if (start_btn) begin
            state_q       <= ST_PLAY;
            game_active_q <= 1'b1;
            frame_cnt_q   <= '0;
          end
        end
        ST_PLAY: begin
          // Win is checked first so a simultaneous final hit and final
          // second resolve as a win.
          if (w_score_win) begin
            state_q       <= ST_WIN;
            game_active_q <= 1'b0;
            result_cnt_q  <= '0;
          end else if (w_time_zero) begin
            state_q       <= ST_LOSE;
            game_active_q <= 1'b0;
            result_cnt_q  <= '0;
          end else if (w_frame_tick) begin
            frame_cnt_q <= w_sec_wrap ? '0 : frame_cnt_q + 1'b1;
          end
        end
        ST_WIN, ST_LOSE: begin
          if (start_btn ||
              (w_frame_tick && (result_cnt_q == RC_W'(RESULT_FRAMES - 1)))) begin
            state_q      <= ST_TITLE;
            result_cnt_q <= '0;
          end else if (w_frame_tick) begin
            result_cnt_q <= result_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q       <= ST_TITLE;
          game_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign screen_sel  = state_q;
  assign game_active = game_active_q;

endmodule
`default_nettype wire

// File: tb/tb_game_screen_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_screen_ctrl
// Description : Self-checking bench for game_screen_ctrl (default parameters).
//               Table of single-cycle vectors followed by directed
//               multi-cycle sequences for countdown, win/lose and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_screen_ctrl;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       start_btn;
  logic       hit_pulse;
  logic [1:0] screen_sel;
  logic [3:0] score_tens, score_ones, time_tens, time_ones;
  logic       game_active;

  int tests;
  int fails;

  game_screen_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .start_btn   (start_btn),
    .hit_pulse   (hit_pulse),
    .screen_sel  (screen_sel),
    .score_tens  (score_tens),
    .score_ones  (score_ones),
    .time_tens   (time_tens),
    .time_ones   (time_ones),
    .game_active (game_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       hit;
    logic [1:0] sel;
    logic [7:0] score;
    logic [7:0] tim;
    logic       act;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] esel,
                       input logic [7:0] esc, input logic [7:0] etim,
                       input logic eact);
    tests++;
    if (screen_sel !== esel || {score_tens, score_ones} !== esc ||
        {time_tens, time_ones} !== etim || game_active !== eact) begin
      fails++;
      $display("FAIL %s: got sel=%0d score=%h time=%h act=%b, want sel=%0d score=%h time=%h act=%b",
               name, screen_sel, {score_tens, score_ones}, {time_tens, time_ones},
               game_active, esel, esc, etim, eact);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
  endtask

  task automatic pulse_hit();
    hit_pulse = 1'b1;
    cyc();
    hit_pulse = 1'b0;
  endtask

  task automatic frame();
    vsync = 1'b0;
    cyc();
    vsync = 1'b1;
    cyc();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b0;
    vsync     = 1'b1;
    start_btn = 1'b0;
    hit_pulse = 1'b0;

    //            rst  start hit  sel   score  time   act
    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h30, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h30, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 8'h30, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd1, 8'h00, 8'h30, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 2'd1, 8'h00, 8'h30, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h01, 8'h30, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h02, 8'h30, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 2'd1, 8'h02, 8'h30, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h03, 8'h30, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 8'h30, 1'b0};

    cyc();
    for (int i = 0; i < 10; i++) begin
      reset     = vecs[i].rst_n;
      start_btn = vecs[i].start;
      hit_pulse = vecs[i].hit;
      cyc();
      check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].score, vecs[i].tim, vecs[i].act);
    end
    reset     = 1'b1;
    start_btn = 1'b0;
    hit_pulse = 1'b0;

    // Win by 20 hits, then result screen timeout
    do_reset();
    pulse_start();
    check("start_play", 2'd1, 8'h00, 8'h30, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      pulse_hit();
      check($sformatf("hit%0d", i), 2'd1, bcd(i), 8'h30, 1'b1);
    end
    cyc();
    check("win_entry", 2'd2, 8'h20, 8'h30, 1'b0);
    pulse_hit();
    check("win_hit_ignored", 2'd2, 8'h20, 8'h30, 1'b0);
    for (int i = 1; i <= 299; i++) frame();
    check("win_hold_299", 2'd2, 8'h20, 8'h30, 1'b0);
    vsync = 1'b0;
    cyc();
    check("win_timeout_title", 2'd0, 8'h20, 8'h30, 1'b0);
    vsync = 1'b1;
    cyc();

    // Second win, leave early with start_btn at frame 10
    pulse_start();
    check("restart_clears", 2'd1, 8'h00, 8'h30, 1'b1);
    for (int i = 1; i <= 20; i++) pulse_hit();
    cyc();
    check("win2_entry", 2'd2, 8'h20, 8'h30, 1'b0);
    for (int i = 1; i <= 10; i++) frame();
    pulse_start();
    check("win_start_title", 2'd0, 8'h20, 8'h30, 1'b0);

    // Full countdown to LOSE
    do_reset();
    pulse_start();
    for (int n = 1; n <= 1799; n++) begin
      frame();
      if (n % 60 == 0)
        check($sformatf("countdown_%0d", n), 2'd1, 8'h00, bcd(30 - n / 60), 1'b1);
    end
    check("time_01", 2'd1, 8'h00, 8'h01, 1'b1);
    vsync = 1'b0;
    cyc();
    check("time_00", 2'd1, 8'h00, 8'h00, 1'b1);
    vsync = 1'b1;
    cyc();
    check("lose_entry", 2'd3, 8'h00, 8'h00, 1'b0);
    pulse_start();
    check("lose_start_title", 2'd0, 8'h00, 8'h00, 1'b0);
    pulse_start();
    check("lose_restart", 2'd1, 8'h00, 8'h30, 1'b1);

    // Final hit and final second in the same cycle: win wins
    do_reset();
    pulse_start();
    for (int i = 1; i <= 19; i++) pulse_hit();
    for (int n = 1; n <= 1799; n++) frame();
    check("tie_setup", 2'd1, 8'h19, 8'h01, 1'b1);
    vsync     = 1'b0;
    hit_pulse = 1'b1;
    cyc();
    hit_pulse = 1'b0;
    check("tie_both_register", 2'd1, 8'h20, 8'h00, 1'b1);
    vsync = 1'b1;
    cyc();
    check("tie_win_priority", 2'd2, 8'h20, 8'h00, 1'b0);

    // Reset mid-round aborts to TITLE
    do_reset();
    pulse_start();
    for (int i = 1; i <= 7; i++) pulse_hit();
    for (int n = 1; n <= 1080; n++) frame();
    check("midround_setup", 2'd1, 8'h07, 8'h12, 1'b1);
    reset = 1'b0;
    cyc();
    check("midround_reset", 2'd0, 8'h00, 8'h30, 1'b0);
    reset = 1'b1;
    pulse_hit();
    check("title_hit_ignored", 2'd0, 8'h00, 8'h30, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
